// File: rtl/game_pkg.sv
// Shared types and constants for the memory game blocks.
package game_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned LFSR_W  = 8;

   localparam logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8;
   localparam logic [DIGIT_W-1:0] SCORE_MAX = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHOW,
      ST_INPUT,
      ST_DONE
   } round_state_e;

   // One Galois step: shift right, fold taps in when the dropped bit is 1.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
      return (q >> 1) ^ (q[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
   endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR; reloads the seed on reset.
module lfsr8
   import game_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= seed;
      end else begin
         q_q <= lfsr_step(q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/memory_round_ctrl.sv
// Memory game round sequencer: grows a random digit pattern, shows it,
// checks the player's echo and keeps score until mismatch or timeout.
module memory_round_ctrl
   import game_pkg::*;
#(
   parameter int unsigned MAX_LEN    = 8,
   parameter int unsigned SHOW_TICKS = 1,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sec_tick,
   input  logic               final_timeout,
   input  logic [DIGIT_W-1:0] entry,
   input  logic               entry_valid,
   output logic               reconfig,
   output logic               timer_enable,
   output logic [DIGIT_W-1:0] show_digit,
   output logic               show_valid,
   output logic [DIGIT_W-1:0] score,
   output logic               game_end,
   output logic               busy
);

   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned ADDR_W = $clog2(MAX_LEN);
   localparam int unsigned TICK_W = 3;

   round_state_e       state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [DIGIT_W-1:0] score_q, score_d;
   logic [DIGIT_W-1:0] pattern_q [MAX_LEN];

   logic               pat_we;
   logic [ADDR_W-1:0]  pat_waddr;
   logic [LFSR_W-1:0]  lfsr_q;
   logic [DIGIT_W-1:0] cur_digit;
   logic               last_idx;
   logic               unused_lfsr_hi;

   lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .q    (lfsr_q)
   );

   assign unused_lfsr_hi = ^lfsr_q[7:4];
   assign cur_digit      = pattern_q[idx_q[ADDR_W-1:0]];
   assign last_idx       = (idx_q == (len_q - LEN_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         tick_q  <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         score_q <= score_d;
      end
   end

   // Pattern slots are always written before they are displayed, so no reset.
   always_ff @(posedge clk) begin
      if (pat_we) begin
         pattern_q[pat_waddr] <= lfsr_q[DIGIT_W-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      tick_d    = tick_q;
      score_d   = score_q;
      pat_we    = 1'b0;
      pat_waddr = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            score_d   = '0;
            len_d     = LEN_W'(1);
            idx_d     = '0;
            tick_d    = '0;
            pat_we    = 1'b1;
            pat_waddr = '0;
            state_d   = ST_SHOW;
         end
         ST_SHOW: begin
            if (final_timeout) begin
               state_d = ST_DONE;
            end else if (sec_tick) begin
               if (tick_q == TICK_W'(SHOW_TICKS - 1)) begin
                  tick_d = '0;
                  if (last_idx) begin
                     idx_d   = '0;
                     state_d = ST_INPUT;
                  end else begin
                     idx_d = idx_q + LEN_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         ST_INPUT: begin
            if (final_timeout) begin
               state_d = ST_DONE;
            end else if (entry_valid) begin
               if (entry != cur_digit) begin
                  state_d = ST_DONE;
               end else if (!last_idx) begin
                  idx_d = idx_q + LEN_W'(1);
               end else begin
                  // Round complete: bump score, grow the pattern if room remains.
                  score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + DIGIT_W'(1);
                  if (len_q < LEN_W'(MAX_LEN)) begin
                     pat_we    = 1'b1;
                     pat_waddr = len_q[ADDR_W-1:0];
                     len_d     = len_q + LEN_W'(1);
                  end
                  idx_d   = '0;
                  tick_d  = '0;
                  state_d = ST_SHOW;
               end
            end
         end
         ST_DONE: begin
            if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign reconfig     = (state_q == ST_LOAD);
   assign timer_enable = (state_q == ST_SHOW) || (state_q == ST_INPUT);
   assign show_valid   = (state_q == ST_SHOW);
   assign show_digit   = show_valid ? cur_digit : '0;
   assign score        = score_q;
   assign game_end     = (state_q == ST_DONE);
   assign busy         = (state_q == ST_LOAD) || (state_q == ST_SHOW) || (state_q == ST_INPUT);

endmodule

// File: doc/memory_round_ctrl.md
# memory_round_ctrl

Round sequencer for the memory game. Once the access controller admits a player, it runs the session:
- pulses the digit-timer reload and gates the one-second timer;
- grows and displays a pseudo-random digit pattern;
- checks the player's button-qualified switch entries against it;
- drives the score toward the score tracker and seven-segment path;
- ends the session on mismatch or countdown expiry.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in digits (2..15)
- SHOW_TICKS, 1, one-second ticks each digit stays displayed (1..7)
- LFSR_SEED, 8'hA5, reset/seed value of pattern LFSR (nonzero)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, player admitted
- sec_tick  in  1  one-cycle pulse from one-second timer
- final_timeout  in  1  countdown reached zero (level or pulse)
- entry  in  4  player digit from switches
- entry_valid  in  1  one-cycle shaped button pulse qualifying entry
- reconfig  out  1  one-cycle pulse, reload digit timers
- timer_enable  out  1  enables one-second timer
- show_digit  out  4  pattern digit being displayed, 0 when not showing
- show_valid  out  1  show_digit meaningful
- score  out  4  completed rounds, saturates at 9
- game_end  out  1  session over, held
- busy  out  1  session in progress (LOAD/SHOW/INPUT)

## Operation
- States: IDLE, LOAD, SHOW, INPUT, DONE.
- **IDLE:**
  - start → LOAD.
  - All other inputs ignored.
- **LOAD** (exactly 1 cycle):
  - reconfig=1; score←0; len←1; pattern[0]←lfsr[3:0]; idx←0; tick_cnt←0.
  - Always → SHOW.
- **SHOW:**
  - show_valid=1; show_digit=pattern[idx].
  - Each sec_tick increments tick_cnt.
  - When tick_cnt reaches SHOW_TICKS: tick_cnt←0 and idx←idx+1.
  - If idx was len−1: idx←0 and → INPUT.
  - entry_valid is ignored.
- **INPUT:**
  - On entry_valid, entry==pattern[idx]:
    - If idx<len−1: idx←idx+1.
    - Else: score←min(score+1,9); if len<MAX_LEN then pattern[len]←lfsr[3:0] and len←len+1; idx←0; → SHOW.
  - On entry_valid with mismatch: → DONE.
- final_timeout in SHOW or INPUT → DONE.
  - final_timeout has priority over entry_valid and sec_tick in the same cycle.
- **DONE:**
  - game_end=1; score is held.
  - start → LOAD.
- start while busy is ignored.
- At len==MAX_LEN, a completed round repeats the same pattern; score still increments and saturates at 9.
- timer_enable=1 in SHOW and INPUT only.
- busy=1 in LOAD, SHOW and INPUT.
- LFSR:
  - 8-bit Galois, taps 8'hB8.
  - Advances every clock in every state.
  - Reset to LFSR_SEED.

## Timing
- All outputs registered or decoded from registered state; no combinational input→output paths.
- Reset (any state, mid-session included), values after the first clock edge with rst=1:
  - State IDLE.
  - reconfig, timer_enable, show_valid, game_end, busy = 0.
  - show_digit=0, score=0, len=0, idx=0.
  - LFSR=LFSR_SEED.
- start at edge n:
  - LOAD visible at n+1, with reconfig=1 for exactly that cycle.
  - SHOW visible at n+2.
- sec_tick completing the last displayed digit at edge n: INPUT (show_valid=0) at n+1.
- entry_valid at edge n: resulting idx, score or state change visible at n+1.
- Round completion: score update and re-entry to SHOW occur on the same edge.
- Mismatch or timeout at edge n: game_end=1 and timer_enable=0 at n+1.

## Structure
- Shared package (game_pkg):
  - State enumeration.
  - SCORE_MAX=9.
  - LFSR_TAPS=8'hB8.
  - Digit width 4.
- Sub-module lfsr8 (clk, rst, seed → q[7:0]), reusable by other game blocks.
- Pattern storage: MAX_LEN×4 register array.

## Test plan
- Reset and start:
  - Stimulus: rst for 2 cycles, then start pulse.
  - Response: outputs 0 during reset; reconfig high exactly 1 cycle; SHOW with show_valid=1; timer_enable=1.
- Correct play, SHOW_TICKS=1:
  - Stimulus: echo each displayed digit for 3 rounds.
  - Response: score steps 1,2,3; displayed lengths 1,2,3; each prefix unchanged from the prior round.
- Mismatch:
  - Stimulus: in round 2, enter (pattern[1]+1)&4'hF.
  - Response: game_end=1 next cycle; score holds 1; timer_enable=0.
- Timeout priority:
  - Stimulus: final_timeout and a correct entry_valid on the same edge in INPUT.
  - Response: DONE; score not incremented.
- Saturation, MAX_LEN=2:
  - Stimulus: 12 correct rounds.
  - Response: length stays 2; score reaches 9 and stays 9.
- Ignore and restart:
  - Stimulus: entry_valid during SHOW → ignored; start while busy → ignored; start in DONE → new session with score=0.
  - Stimulus: rst mid-INPUT.
  - Response: IDLE with all outputs 0 after one edge.
